spi_slave_frame_monitor: RTL and testbench

// Synthesizable SPI bus monitor on the slave side. It oversamples sclk, cs, mosi0 and miso0 in the pclk domain,

---
 rtl/spi_slave_frame_monitor.sv | 243 ++++++++++++++++++++++++
 tb/tb_spi_slave_frame_monitor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_frame_monitor.sv
// spi_slave_frame_monitor
// Slave-side SPI bus monitor. It oversamples sclk/cs/mosi0/miso0 in the pclk
// domain and deserialises MOSI and MISO into DATA_WIDTH-bit words. All four
// CPOL/CPHA modes are supported, MSB- or LSB-first. Completed word pairs are
// buffered in a FIFO that drains through a valid/ready port. The monitor
// flags frames that end on a partial word and words dropped on FIFO overflow.
//
// Ports
//   pclk, areset          system clock, synchronous active-high reset
//   cfg_en                monitor enable, sampled only while idle
//   cfg_cpol/cfg_cpha     SPI mode, latched at cs fall
//   cfg_msb_first         bit order, latched at cs fall
//   sclk, cs, mosi0, miso0  raw SPI bus (asynchronous to pclk)
//   out_valid/out_ready   FIFO drain handshake
//   out_mosi/out_miso     head word pair
//   out_first             head word was the first word after a cs fall
//   fifo_level            FIFO occupancy
//   frame_err/err_bits    pulse and bit count when cs rises mid-word
//   overflow/overflow_clr sticky word-dropped flag and its clear
module spi_slave_frame_monitor #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          pclk,
  input  logic                          areset,
  input  logic                          cfg_en,
  input  logic                          cfg_cpol,
  input  logic                          cfg_cpha,
  input  logic                          cfg_msb_first,
  input  logic                          sclk,
  input  logic                          cs,
  input  logic                          mosi0,
  input  logic                          miso0,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_mosi,
  output logic [DATA_WIDTH-1:0]         out_miso,
  output logic                          out_first,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic [$clog2(DATA_WIDTH)-1:0] err_bits,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 * DATA_WIDTH + 1;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

  // ---------------------------------------------------------------- sync
  // cs synchroniser resets low: a reset taken while cs is held low must not
  // see a fake cs fall, so WAIT_IDLE waits for a genuine high level first.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, miso_sync;
  logic                   sclk_hist, cs_hist;

  always_ff @(posedge pclk) begin
    if (areset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      cs_hist   <= cs_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge pclk) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi0};
    miso_sync <= {miso_sync[SYNC_STAGES-2:0], miso0};
  end

  logic sclk_s, cs_s, mosi_s, miso_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign miso_s    = miso_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign cs_rise   = cs_s & ~cs_hist;
  assign cs_fall   = ~cs_s & cs_hist;

  // ---------------------------------------------------------------- frame FSM
  state_t                  state, state_nxt;
  logic [CW-1:0]           bit_cnt, bit_cnt_nxt;
  logic                    first_pend, first_pend_nxt;
  logic                    cpol_l, cpha_l, msb_l;
  logic                    cpol_nxt, cpha_nxt, msb_nxt;
  logic [DATA_WIDTH-1:0]   sr_mosi, sr_miso, sr_mosi_nxt, sr_miso_nxt;
  logic                    frame_err_nxt;
  logic [CW-1:0]           err_bits_nxt;
  logic                    push, samp_edge;
  logic [EW-1:0]           push_word;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling.
  assign samp_edge = (cpol_l == cpha_l) ? sclk_rise : sclk_fall;

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    first_pend_nxt = first_pend;
    cpol_nxt       = cpol_l;
    cpha_nxt       = cpha_l;
    msb_nxt        = msb_l;
    sr_mosi_nxt    = sr_mosi;
    sr_miso_nxt    = sr_miso;
    frame_err_nxt  = 1'b0;
    err_bits_nxt   = err_bits;
    push           = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (cs_s) state_nxt = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          if (cfg_en) begin
            cpol_nxt       = cfg_cpol;
            cpha_nxt       = cfg_cpha;
            msb_nxt        = cfg_msb_first;
            bit_cnt_nxt    = '0;
            first_pend_nxt = 1'b1;
            state_nxt      = ACTIVE;
          end else begin
            state_nxt = WAIT_IDLE;
          end
        end
      end
      ACTIVE: begin
        // The bit is taken before a coincident cs rise is evaluated, so a
        // last bit and cs rise in the same cycle still complete the word.
        if (samp_edge) begin
          if (msb_l) begin
            sr_mosi_nxt = {sr_mosi[DATA_WIDTH-2:0], mosi_s};
            sr_miso_nxt = {sr_miso[DATA_WIDTH-2:0], miso_s};
          end else begin
            sr_mosi_nxt = {mosi_s, sr_mosi[DATA_WIDTH-1:1]};
            sr_miso_nxt = {miso_s, sr_miso[DATA_WIDTH-1:1]};
          end
          if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
            push           = 1'b1;
            bit_cnt_nxt    = '0;
            first_pend_nxt = 1'b0;
          end else begin
            bit_cnt_nxt = bit_cnt + CW'(1);
          end
        end
        if (cs_rise) begin
          state_nxt = IDLE;
          if (bit_cnt_nxt != '0) begin
            frame_err_nxt = 1'b1;
            err_bits_nxt  = bit_cnt_nxt;
          end
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  assign push_word = {sr_mosi_nxt, sr_miso_nxt, first_pend};

  always_ff @(posedge pclk) begin
    if (areset) begin
      state      <= WAIT_IDLE;
      bit_cnt    <= '0;
      first_pend <= 1'b0;
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      msb_l      <= 1'b0;
      frame_err  <= 1'b0;
      err_bits   <= '0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      first_pend <= first_pend_nxt;
      cpol_l     <= cpol_nxt;
      cpha_l     <= cpha_nxt;
      msb_l      <= msb_nxt;
      frame_err  <= frame_err_nxt;
      err_bits   <= err_bits_nxt;
    end
  end

  always_ff @(posedge pclk) begin
    sr_mosi <= sr_mosi_nxt;
    sr_miso <= sr_miso_nxt;
  end

  // ---------------------------------------------------------------- FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [LW-1:0] level_nxt;
  logic          pop, full, wr_en, ovf_set;
  logic [EW-1:0] head_nxt;

  assign out_valid  = (fifo_level != '0);
  assign pop        = out_valid & out_ready;
  assign full       = (fifo_level == LW'(FIFO_DEPTH));
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign wr_en      = push & (~full | pop);
  assign ovf_set    = push & full & ~pop;
  assign rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign wr_ptr_nxt = wr_en ? wr_ptr + AW'(1) : wr_ptr;
  assign level_nxt  = fifo_level + LW'(wr_en) - LW'(pop);

  // The next head is the word being written when the FIFO is (or becomes)
  // otherwise empty; the outputs register it so out_* line up with out_valid.
  always_comb begin
    head_nxt = mem[rd_ptr_nxt];
    if (wr_en && (rd_ptr_nxt == wr_ptr)) head_nxt = push_word;
  end

  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      out_mosi   <= '0;
      out_miso   <= '0;
      out_first  <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      fifo_level <= level_nxt;
      if (ovf_set)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      if (level_nxt != '0) {out_mosi, out_miso, out_first} <= head_nxt;
    end
  end

endmodule

// File: tb/tb_spi_slave_frame_monitor.sv
module tb_spi_slave_frame_monitor;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int H     = 40;  // sclk half period (4 pclk)
  localparam int D     = 20;  // data hold after the shifting edge

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic areset = 1'b1, cfg_en = 1'b1, cfg_cpol = 1'b0, cfg_cpha = 1'b0;
  logic cfg_msb_first = 1'b1, sclk = 1'b0, cs = 1'b1, mosi0 = 1'b0, miso0 = 1'b0;
  logic overflow_clr = 1'b0, rdy_base = 1'b0, rdy_pulse = 1'b0, out_ready;
  logic out_valid, out_first, frame_err, overflow;
  logic [W-1:0] out_mosi, out_miso;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [$clog2(W)-1:0] err_bits;

  assign out_ready = rdy_base | rdy_pulse;

  spi_slave_frame_monitor #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .pclk(pclk), .areset(areset), .cfg_en(cfg_en), .cfg_cpol(cfg_cpol),
    .cfg_cpha(cfg_cpha), .cfg_msb_first(cfg_msb_first), .sclk(sclk), .cs(cs),
    .mosi0(mosi0), .miso0(miso0), .out_valid(out_valid), .out_ready(out_ready),
    .out_mosi(out_mosi), .out_miso(out_miso), .out_first(out_first),
    .fifo_level(fifo_level), .frame_err(frame_err), .err_bits(err_bits),
    .overflow(overflow), .overflow_clr(overflow_clr));

  typedef struct packed {
    logic [W-1:0] mosi;
    logic [W-1:0] miso;
    logic         first;
  } entry_t;

  entry_t sb[$];
  int     err_q[$];
  int     checks = 0;
  int     errors = 0;
  int     rdy_mode = 0;  // 0 hold low, 1 hold high, 2 random
  bit     exp_ovf = 1'b0;
  bit     fr_mosi [0:63];
  bit     fr_miso [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list the line values present at every sclk edge of the
  // frame, keep those on the configured sampling polarity, group into words.
  function automatic void model(input bit dcpol, dcpha, ccpol, ccpha, msb, en,
                                input int n, input bit no_drain, pop_last);
    bit sm[$];
    bit ss[$];
    bit samp_rise;
    int nw;
    entry_t e;
    if (!en) return;
    samp_rise = (ccpol == ccpha);
    for (int i = 0; i < n; i++) begin
      if ((dcpol == 1'b0) == samp_rise) begin  // leading edge
        if (dcpha == 1'b0) begin
          sm.push_back(fr_mosi[i]); ss.push_back(fr_miso[i]);
        end else if (i == 0) begin
          sm.push_back(1'b0); ss.push_back(1'b0);
        end else begin
          sm.push_back(fr_mosi[i-1]); ss.push_back(fr_miso[i-1]);
        end
      end
      if ((dcpol == 1'b1) == samp_rise) begin  // trailing edge
        sm.push_back(fr_mosi[i]); ss.push_back(fr_miso[i]);
      end
    end
    nw = sm.size() / W;
    for (int w = 0; w < nw; w++) begin
      e = '0;
      for (int k = 0; k < W; k++) begin
        if (msb) begin
          e.mosi[W-1-k] = sm[w*W+k]; e.miso[W-1-k] = ss[w*W+k];
        end else begin
          e.mosi[k] = sm[w*W+k]; e.miso[k] = ss[w*W+k];
        end
      end
      e.first = (w == 0);
      if (no_drain && sb.size() >= DEPTH && !(pop_last && w == nw - 1)) exp_ovf = 1'b1;
      else sb.push_back(e);
    end
    if (sm.size() % W != 0) err_q.push_back(sm.size() % W);
  endfunction

  task automatic set_word(input int idx, input logic [W-1:0] m, input logic [W-1:0] s,
                          input bit msb);
    for (int k = 0; k < W; k++) begin
      fr_mosi[idx*W+k] = msb ? m[W-1-k] : m[k];
      fr_miso[idx*W+k] = msb ? s[W-1-k] : s[k];
    end
  endtask

  // SPI master: shifts data on the non-sampling edge of the driven mode.
  task automatic run_frame(input bit dcpol, dcpha, ccpol, ccpha, msb, en, input int n,
                           input bit no_drain, pop_last, input int rst_bit);
    @(posedge pclk); #3;
    cfg_en = en; cfg_cpol = ccpol; cfg_cpha = ccpha; cfg_msb_first = msb;
    sclk = dcpol; mosi0 = 1'b0; miso0 = 1'b0;
    if (rst_bit < 0) model(dcpol, dcpha, ccpol, ccpha, msb, en, n, no_drain, pop_last);
    #80;
    cs = 1'b0;
    if (!dcpha) begin mosi0 = fr_mosi[0]; miso0 = fr_miso[0]; end
    #H;
    cfg_en = 1'($urandom); cfg_cpol = 1'($urandom);
    cfg_cpha = 1'($urandom); cfg_msb_first = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      if (!dcpha) begin
        sclk = ~dcpol;
        if (pop_last && i == n - 1) fork begin #19; rdy_pulse = 1'b1; #10; rdy_pulse = 1'b0; end join_none
        #H; sclk = dcpol; #D;
        if (i < n - 1) begin mosi0 = fr_mosi[i+1]; miso0 = fr_miso[i+1]; end
        if (i == rst_bit) begin
          areset = 1'b1; #10; areset = 1'b0; exp_ovf = 1'b0; #(H-D-10);
        end else #(H-D);
      end else begin
        sclk = ~dcpol; #D;
        mosi0 = fr_mosi[i]; miso0 = fr_miso[i]; #(H-D);
        sclk = dcpol;
        if (pop_last && i == n - 1) fork begin #19; rdy_pulse = 1'b1; #10; rdy_pulse = 1'b0; end join_none
        #H;
      end
    end
    cs = 1'b1;
    #H;
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(posedge pclk);
    end
    repeat (3) @(posedge pclk);
    check("drain_empty", sb.size(), 0);
    sb.delete();
  endtask

  // Ready driver
  initial forever begin
    @(posedge pclk); #2;
    case (rdy_mode)
      0:       rdy_base = 1'b0;
      1:       rdy_base = 1'b1;
      default: rdy_base = 1'($urandom);
    endcase
  end

  // Monitor / scoreboard
  entry_t got_exp;
  initial forever begin
    @(negedge pclk);
    if (!areset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h/%0h first %0b expected none", out_mosi, out_miso, out_first);
        end else begin
          got_exp = sb.pop_front();
          check("out_mosi", out_mosi, got_exp.mosi);
          check("out_miso", out_miso, got_exp.miso);
          check("out_first", out_first, got_exp.first);
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_err: got err_bits %0d expected no pulse", err_bits);
        end else check("err_bits", err_bits, err_q.pop_front());
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] m;
    bit msb, en;
    int n;
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    check("rst_valid", out_valid, 0);   check("rst_level", fifo_level, 0);
    check("rst_ferr", frame_err, 0);    check("rst_ovf", overflow, 0);
    check("rst_mosi", out_mosi, 0);     check("rst_miso", out_miso, 0);
    check("rst_first", out_first, 0);   check("rst_errbits", err_bits, 0);
    @(posedge pclk); #3; areset = 1'b0;
    repeat (5) @(posedge pclk);

    // Mode 0 MSB-first A5/3C, held in the FIFO
    rdy_mode = 0;
    set_word(0, 8'hA5, 8'h3C, 1);
    run_frame(0, 0, 0, 0, 1, 1, 8, 0, 0, -1);
    check("mode0_level", fifo_level, 1);
    check("mode0_valid", out_valid, 1);
    drain();

    // Modes 1..3, then every mode against the opposite sampling edge
    for (int k = 1; k < 4; k++) begin
      m = 2'(k);
      run_frame(m[1], m[0], m[1], m[0], 1, 1, 8, 0, 0, -1);
    end
    for (int k = 0; k < 4; k++) begin
      m = 2'(k);
      run_frame(m[1], m[0], m[1], ~m[0], 1, 1, 8, 0, 0, -1);
    end
    drain();

    // LSB-first: first bit on the wire is 1, rest 0
    set_word(0, 8'h00, 8'h96, 0);
    fr_mosi[0] = 1'b1;
    run_frame(0, 0, 0, 0, 0, 1, 8, 0, 0, -1);
    drain();

    // Three bytes under one cs
    rdy_mode = 0;
    set_word(0, 8'h11, 8'hE1, 1); set_word(1, 8'h22, 8'hD2, 1); set_word(2, 8'h33, 8'hC3, 1);
    run_frame(0, 0, 0, 0, 1, 1, 24, 0, 0, -1);
    check("three_level", fifo_level, 3);
    drain();

    // Short frame, then a clean frame
    set_word(0, 8'hF0, 8'h0F, 1);
    run_frame(1, 1, 1, 1, 1, 1, 5, 0, 0, -1);
    set_word(0, 8'h5A, 8'hC3, 1);
    run_frame(1, 1, 1, 1, 1, 1, 8, 0, 0, -1);
    drain();

    // Overflow: five words with no drain, then a push with a coincident pop
    rdy_mode = 0;
    for (int w = 0; w < 5; w++) set_word(w, W'(8'h10 + w), W'(8'hA0 + w), 1);
    run_frame(0, 0, 0, 0, 1, 1, 40, 1, 0, -1);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, exp_ovf);
    @(posedge pclk); #3; overflow_clr = 1'b1; exp_ovf = 1'b0;
    @(posedge pclk); #3; overflow_clr = 1'b0;
    @(negedge pclk);
    check("ovf_clr", overflow, 0);
    set_word(0, 8'h77, 8'h88, 1);
    run_frame(0, 0, 0, 0, 1, 1, 8, 1, 1, -1);
    check("pushpop_level", fifo_level, 4);
    check("pushpop_ovf", overflow, 0);
    drain();

    // Reset at bit 3 with cs held low: nothing captured from that frame
    set_word(0, 8'hC3, 8'h3C, 1);
    run_frame(0, 0, 0, 0, 1, 1, 8, 0, 0, 3);
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    check("rstmid_level", fifo_level, 0);
    check("rstmid_ovf", overflow, 0);
    set_word(0, 8'h69, 8'h96, 1);
    run_frame(0, 0, 0, 0, 1, 1, 8, 0, 0, -1);
    // Disabled frame, then a normal one
    run_frame(0, 0, 0, 0, 1, 0, 8, 0, 0, -1);
    run_frame(0, 0, 0, 0, 1, 1, 8, 0, 0, -1);
    drain();

    // Randomised frames with random back-pressure
    rdy_mode = 2;
    for (int f = 0; f < 30; f++) begin
      m   = 2'($urandom_range(0, 3));
      msb = 1'($urandom);
      n   = $urandom_range(1, 24);
      en  = ($urandom_range(0, 7) != 0);
      for (int w = 0; w < 3; w++) set_word(w, W'($urandom), W'($urandom), msb);
      run_frame(m[1], m[0], m[1], m[0], msb, en, n, 0, 0, -1);
    end
    drain();
    repeat (10) @(posedge pclk);
    check("err_q_empty", err_q.size(), 0);
    check("final_ovf", overflow, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
